// File: rtl/apu_dispatcher_pkg.sv
// Shared types for the APU offload dispatcher: command/response payloads,
// dispatcher FSM states and a saturating increment used by the optional
// performance counters.
package apu_dispatcher_pkg;

  localparam int PERF_W = 32;

  typedef struct packed {
    logic [2:0][31:0] operands;
    logic [5:0]       op;
    logic [14:0]      flags;
  } apu_cmd_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  flags;
  } apu_rsp_t;

  typedef enum logic {
    APU_DISP_IDLE,
    APU_DISP_REQ
  } apu_disp_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

endpackage

// File: rtl/apu_sync_fifo.sv
// Synchronous FIFO with a type parameter, used for both the command queue and
// the response buffer. Pointers carry an extra wrap bit so full and empty are
// distinguishable; DEPTH must be a power of two, at least 2. Push when full and
// pop when empty are ignored.
module apu_sync_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  T                         wr_data,
  input  logic                     pop,
  output T                         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  T            mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == FULL_COUNT);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset empties the FIFO.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; the pointers alone
    // define which entries are valid, and this keeps the array mappable to RAM.
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/apu_dispatcher.sv
// Core-side initiator of the APU offload interface. Commands from the scalar
// pipeline are queued, issued one per cycle over apu_req/apu_gnt, and their
// in-order results are buffered for the core with valid/ready backpressure.
// Issue is credit-limited so the unbackpressured apu_rvalid always has room.
// Optional: define APU_DISPATCH_PERF_EN to add saturating performance counters.
module apu_dispatcher
  import apu_dispatcher_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [2:0][31:0]  cmd_operands_i,
  input  logic [5:0]        cmd_op_i,
  input  logic [14:0]       cmd_flags_i,
  output logic              apu_req,
  output logic [2:0][31:0]  apu_operands_o,
  output logic [5:0]        apu_op_o,
  output logic [14:0]       apu_flags_o,
  input  logic              apu_gnt,
  input  logic              apu_rvalid,
  input  logic [31:0]       apu_result,
  input  logic [4:0]        apu_flags_i,
  input  logic              core_halt_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_result_o,
  output logic [4:0]        rsp_flags_o,
  output logic              busy_o
`ifdef APU_DISPATCH_PERF_EN
  ,
  output logic [31:0]       perf_issued_o,
  output logic [31:0]       perf_stall_credit_o,
  output logic [31:0]       perf_stall_halt_o
`endif
);

  localparam int CMD_CW = $clog2(CMD_DEPTH) + 1;
  localparam int CNT_W  = $clog2(RSP_DEPTH) + 1;
  localparam logic [CNT_W-1:0] RSP_CAP = CNT_W'(RSP_DEPTH);

  apu_disp_state_t   state;
  apu_cmd_t          cmd_in;
  apu_cmd_t          cmd_head;
  apu_rsp_t          rsp_in;
  apu_rsp_t          rsp_head;
  logic              cmd_full, cmd_empty, rsp_full, rsp_empty;
  logic [CMD_CW-1:0] cmd_count;
  logic [CNT_W-1:0]  rsp_count;
  logic [CNT_W-1:0]  inflight, inflight_next, rsp_count_next;
  logic [CNT_W-1:0]  credits, credits_next;
  logic              cmd_push, gnt_fire, rsp_push, rsp_pop, next_head_valid;

  assign cmd_in   = '{operands: cmd_operands_i, op: cmd_op_i, flags: cmd_flags_i};
  assign rsp_in   = '{result: apu_result, flags: apu_flags_i};
  assign cmd_push = cmd_valid_i & cmd_ready_o;
  assign gnt_fire = apu_req & apu_gnt;
  // A response with nothing outstanding is a protocol error and is dropped.
  assign rsp_push = apu_rvalid & (inflight != '0);
  assign rsp_pop  = rsp_valid_o & rsp_ready_i;

  apu_sync_fifo #(.T(apu_cmd_t), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (cmd_push),
    .wr_data (cmd_in),
    .pop     (gnt_fire),
    .rd_data (cmd_head),
    .full    (cmd_full),
    .empty   (cmd_empty),
    .count   (cmd_count)
  );

  apu_sync_fifo #(.T(apu_rsp_t), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (rsp_push),
    .wr_data (rsp_in),
    .pop     (rsp_pop),
    .rd_data (rsp_head),
    .full    (rsp_full),
    .empty   (rsp_empty),
    .count   (rsp_count)
  );

  // Credit accounting: current and post-edge occupancy of the response path.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path (here
    // unconditionally) so no latch is inferred.
    inflight_next   = inflight + CNT_W'(gnt_fire) - CNT_W'(rsp_push);
    rsp_count_next  = rsp_count + CNT_W'(rsp_push) - CNT_W'(rsp_pop);
    credits         = RSP_CAP - inflight - rsp_count;
    credits_next    = RSP_CAP - inflight_next - rsp_count_next;
    next_head_valid = (cmd_count > CMD_CW'(1)) | cmd_push;
  end

  // Issue FSM with registered apu_req; a raised request is never withdrawn.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= APU_DISP_IDLE;
      apu_req  <= 1'b0;
      inflight <= '0;
    end else begin
      inflight <= inflight_next;
      case (state)
        APU_DISP_IDLE: begin
          if (!cmd_empty && (credits != '0) && !core_halt_i) begin
            state   <= APU_DISP_REQ;
            apu_req <= 1'b1;
          end
        end
        APU_DISP_REQ: begin
          if (apu_gnt && !(next_head_valid && (credits_next != '0) && !core_halt_i)) begin
            state   <= APU_DISP_IDLE;
            apu_req <= 1'b0;
          end
        end
        default: begin
          state   <= APU_DISP_IDLE;
          apu_req <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o    = ~cmd_full;
  assign apu_operands_o = cmd_head.operands;
  assign apu_op_o       = cmd_head.op;
  assign apu_flags_o    = cmd_head.flags;
  assign rsp_valid_o    = ~rsp_empty;
  assign rsp_result_o   = rsp_head.result;
  assign rsp_flags_o    = rsp_head.flags;
  assign busy_o         = ~cmd_empty | (inflight != '0) | ~rsp_empty | (state == APU_DISP_REQ);

`ifdef APU_DISPATCH_PERF_EN
  // Saturating counters for grants, credit stalls and halt stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issued_o       <= '0;
      perf_stall_credit_o <= '0;
      perf_stall_halt_o   <= '0;
    end else begin
      if (gnt_fire)                      perf_issued_o       <= sat_inc(perf_issued_o);
      if (!cmd_empty && credits == '0)   perf_stall_credit_o <= sat_inc(perf_stall_credit_o);
      if (!cmd_empty && core_halt_i)     perf_stall_halt_o   <= sat_inc(perf_stall_halt_o);
    end
  end
`endif

  a_rvalid_outstanding: assert property (@(posedge clk) disable iff (reset)
    apu_rvalid |-> (inflight != '0));
  a_rsp_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(rsp_full && rsp_push && !rsp_pop));

endmodule

// File: tb/tb_apu_dispatcher.sv
// Directed testbench for apu_dispatcher (default build, 4-entry FIFOs).
module tb_apu_dispatcher;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid_i, cmd_ready_o;
  logic [2:0][31:0] cmd_operands_i;
  logic [5:0]       cmd_op_i;
  logic [14:0]      cmd_flags_i;
  logic             apu_req;
  logic [2:0][31:0] apu_operands_o;
  logic [5:0]       apu_op_o;
  logic [14:0]      apu_flags_o;
  logic             apu_gnt, apu_rvalid;
  logic [31:0]      apu_result;
  logic [4:0]       apu_flags_i;
  logic             core_halt_i;
  logic             rsp_valid_o, rsp_ready_i;
  logic [31:0]      rsp_result_o;
  logic [4:0]       rsp_flags_o;
  logic             busy_o;

  always #5 clk = ~clk;

  apu_dispatcher dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_operands_i (cmd_operands_i),
    .cmd_op_i       (cmd_op_i),
    .cmd_flags_i    (cmd_flags_i),
    .apu_req        (apu_req),
    .apu_operands_o (apu_operands_o),
    .apu_op_o       (apu_op_o),
    .apu_flags_o    (apu_flags_o),
    .apu_gnt        (apu_gnt),
    .apu_rvalid     (apu_rvalid),
    .apu_result     (apu_result),
    .apu_flags_i    (apu_flags_i),
    .core_halt_i    (core_halt_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_result_o   (rsp_result_o),
    .rsp_flags_o    (rsp_flags_o),
    .busy_o         (busy_o)
  );

  int checks = 0;
  int errors = 0;

  // Small environment model: command source, accelerator answering each grant
  // one cycle later (when auto_rv is set), and a log of observed traffic.
  int          to_push, pushed, grants, pend, rv_sent, ready_stalls, cyc, op_base;
  bit          auto_rv;
  logic [31:0] popped_q[$];
  logic [5:0]  req_ops_q[$];
  int          req_cyc_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    to_push = 0; pushed = 0; grants = 0; pend = 0; rv_sent = 0;
    ready_stalls = 0; cyc = 0; op_base = 0; auto_rv = 0;
    popped_q.delete(); req_ops_q.delete(); req_cyc_q.delete();
    cmd_valid_i = 0; apu_rvalid = 0; apu_gnt = 0; rsp_ready_i = 0; core_halt_i = 0;
  endtask

  task automatic cycle();
    bit p, g, r;
    cmd_valid_i    = (pushed < to_push);
    cmd_op_i       = 6'(op_base + pushed);
    cmd_operands_i = {3{32'(pushed)}};
    cmd_flags_i    = 15'(pushed);
    apu_rvalid     = auto_rv && (pend > 0);
    apu_result     = 32'h200 + 32'(rv_sent);
    apu_flags_i    = 5'(rv_sent);
    p = cmd_valid_i && cmd_ready_o;
    g = apu_req && apu_gnt;
    r = apu_rvalid;
    if (cmd_valid_i && !cmd_ready_o) ready_stalls++;
    if (apu_req) begin
      req_ops_q.push_back(apu_op_o);
      req_cyc_q.push_back(cyc);
    end
    if (rsp_valid_o && rsp_ready_i) popped_q.push_back(rsp_result_o);
    step();
    cyc++;
    pushed  += int'(p);
    grants  += int'(g);
    pend     = pend + int'(g) - int'(r);
    rv_sent += int'(r);
  endtask

  task automatic test_reset();
    clear_model();
    reset = 1'b1;
    cmd_operands_i = '0; cmd_op_i = '0; cmd_flags_i = '0;
    apu_result = '0; apu_flags_i = '0;
    step(); step();
    checks++; if (apu_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b exp 0", apu_req); end
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b exp 0", rsp_valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy_o); end
    checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %0b exp 1", cmd_ready_o); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    clear_model();
    cmd_valid_i = 1; cmd_op_i = 6'h01; cmd_flags_i = 15'h1234;
    cmd_operands_i = {32'h3, 32'h2, 32'h1};
    apu_gnt = 1;
    step();
    cmd_valid_i = 0;
    checks++; if (apu_req !== 1'b0) begin errors++; $display("FAIL single_req_early got %0b exp 0", apu_req); end
    step();
    checks++; if (apu_req !== 1'b1) begin errors++; $display("FAIL single_req got %0b exp 1", apu_req); end
    checks++; if (apu_op_o !== 6'h01) begin errors++; $display("FAIL single_op got %h exp 01", apu_op_o); end
    checks++; if (apu_operands_o !== {32'h3, 32'h2, 32'h1}) begin errors++; $display("FAIL single_operands got %h", apu_operands_o); end
    checks++; if (apu_flags_o !== 15'h1234) begin errors++; $display("FAIL single_flags got %h exp 1234", apu_flags_o); end
    step();
    apu_gnt = 0;
    checks++; if (apu_req !== 1'b0) begin errors++; $display("FAIL single_req_drop got %0b exp 0", apu_req); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL single_busy_inflight got %0b exp 1", busy_o); end
    step(); step();
    apu_rvalid = 1; apu_result = 32'h0000_0010; apu_flags_i = 5'h03;
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL single_rsp_latency got %0b exp 0", rsp_valid_o); end
    step();
    apu_rvalid = 0;
    checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got %0b exp 1", rsp_valid_o); end
    checks++; if (rsp_result_o !== 32'h10) begin errors++; $display("FAIL single_rsp_data got %h exp 00000010", rsp_result_o); end
    checks++; if (rsp_flags_o !== 5'h03) begin errors++; $display("FAIL single_rsp_flags got %h exp 03", rsp_flags_o); end
    rsp_ready_i = 1;
    step();
    rsp_ready_i = 0;
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL single_rsp_pop got %0b exp 0", rsp_valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %0b exp 0", busy_o); end
  endtask

  task automatic test_back_to_back();
    clear_model();
    op_base = 6'h0A; to_push = 4; apu_gnt = 1;
    repeat (8) cycle();
    checks++; if (req_ops_q.size() !== 4) begin errors++; $display("FAIL b2b_req_count got %0d exp 4", req_ops_q.size()); end
    for (int i = 0; i < 4 && i < req_ops_q.size(); i++) begin
      checks++;
      if (req_ops_q[i] !== 6'(op_base + i)) begin errors++; $display("FAIL b2b_op[%0d] got %h exp %h", i, req_ops_q[i], 6'(op_base + i)); end
    end
    if (req_cyc_q.size() == 4) begin
      checks++;
      if (req_cyc_q[3] - req_cyc_q[0] != 3) begin errors++; $display("FAIL b2b_consecutive got span %0d exp 3", req_cyc_q[3] - req_cyc_q[0]); end
    end
    checks++; if (ready_stalls !== 0) begin errors++; $display("FAIL b2b_cmd_ready got %0d stalls exp 0", ready_stalls); end
    auto_rv = 1; rsp_ready_i = 1;
    repeat (12) cycle();
    checks++; if (popped_q.size() !== 4) begin errors++; $display("FAIL b2b_rsp_count got %0d exp 4", popped_q.size()); end
    for (int i = 0; i < 4 && i < popped_q.size(); i++) begin
      checks++;
      if (popped_q[i] !== 32'h200 + 32'(i)) begin errors++; $display("FAIL b2b_rsp[%0d] got %h exp %h", i, popped_q[i], 32'h200 + 32'(i)); end
    end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL b2b_busy got %0b exp 0", busy_o); end
  endtask

  task automatic test_credit();
    clear_model();
    op_base = 6'h20; to_push = 6; apu_gnt = 1; auto_rv = 1;
    repeat (30) cycle();
    checks++; if (grants !== 4) begin errors++; $display("FAIL credit_grants got %0d exp 4", grants); end
    checks++; if (pushed !== 6) begin errors++; $display("FAIL credit_pushed got %0d exp 6", pushed); end
    checks++; if (apu_req !== 1'b0) begin errors++; $display("FAIL credit_req_blocked got %0b exp 0", apu_req); end
    checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL credit_rsp_valid got %0b exp 1", rsp_valid_o); end
    rsp_ready_i = 1;
    repeat (30) cycle();
    checks++; if (grants !== 6) begin errors++; $display("FAIL credit_grants_after got %0d exp 6", grants); end
    checks++; if (popped_q.size() !== 6) begin errors++; $display("FAIL credit_rsp_count got %0d exp 6", popped_q.size()); end
    for (int i = 0; i < 6 && i < popped_q.size(); i++) begin
      checks++;
      if (popped_q[i] !== 32'h200 + 32'(i)) begin errors++; $display("FAIL credit_rsp[%0d] got %h exp %h", i, popped_q[i], 32'h200 + 32'(i)); end
    end
    for (int i = 0; i < 6 && i < req_ops_q.size(); i++) begin
      checks++;
      if (req_ops_q[i] !== 6'(op_base + i)) begin errors++; $display("FAIL credit_op[%0d] got %h exp %h", i, req_ops_q[i], 6'(op_base + i)); end
    end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL credit_busy got %0b exp 0", busy_o); end
  endtask

  task automatic test_halt();
    clear_model();
    op_base = 6'h28; to_push = 1; core_halt_i = 1; apu_gnt = 1;
    repeat (6) cycle();
    checks++; if (req_ops_q.size() !== 0) begin errors++; $display("FAIL halt_req_cycles got %0d exp 0", req_ops_q.size()); end
    checks++; if (pushed !== 1) begin errors++; $display("FAIL halt_pushed got %0d exp 1", pushed); end
    core_halt_i = 0;
    cycle();
    checks++; if (apu_req !== 1'b1) begin errors++; $display("FAIL halt_release_req got %0b exp 1", apu_req); end
    cycle();
    checks++; if (grants !== 1) begin errors++; $display("FAIL halt_grant got %0d exp 1", grants); end
    auto_rv = 1; rsp_ready_i = 1;
    repeat (5) cycle();
    checks++; if (popped_q.size() !== 1) begin errors++; $display("FAIL halt_rsp_count got %0d exp 1", popped_q.size()); end
    // Halt raised while a request is pending must not retract it.
    auto_rv = 0; rsp_ready_i = 0; apu_gnt = 0; to_push = 2;
    repeat (3) cycle();
    checks++; if (apu_req !== 1'b1) begin errors++; $display("FAIL halt_pending_req got %0b exp 1", apu_req); end
    core_halt_i = 1;
    repeat (3) cycle();
    checks++; if (apu_req !== 1'b1) begin errors++; $display("FAIL halt_req_held got %0b exp 1", apu_req); end
    checks++; if (apu_op_o !== 6'h29) begin errors++; $display("FAIL halt_held_op got %h exp 29", apu_op_o); end
    apu_gnt = 1;
    cycle();
    checks++; if (grants !== 2) begin errors++; $display("FAIL halt_held_grant got %0d exp 2", grants); end
    checks++; if (apu_req !== 1'b0) begin errors++; $display("FAIL halt_after_grant got %0b exp 0", apu_req); end
    core_halt_i = 0; apu_gnt = 0; auto_rv = 1; rsp_ready_i = 1;
    repeat (5) cycle();
    checks++; if (popped_q.size() !== 2) begin errors++; $display("FAIL halt_rsp_total got %0d exp 2", popped_q.size()); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL halt_busy got %0b exp 0", busy_o); end
  endtask

  task automatic test_reset_mid();
    clear_model();
    op_base = 6'h30; to_push = 3; apu_gnt = 1;
    repeat (8) cycle();
    checks++; if (grants !== 3) begin errors++; $display("FAIL rstmid_grants got %0d exp 3", grants); end
    auto_rv = 1;
    cycle();
    auto_rv = 0; apu_rvalid = 0;
    checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL rstmid_buffered got %0b exp 1", rsp_valid_o); end
    reset = 1; apu_rvalid = 1; apu_result = 32'hDEAD_BEEF;
    step();
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_rsp_valid got %0b exp 0", rsp_valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %0b exp 0", busy_o); end
    checks++; if (apu_req !== 1'b0) begin errors++; $display("FAIL rstmid_req got %0b exp 0", apu_req); end
    checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_cmd_ready got %0b exp 1", cmd_ready_o); end
    reset = 0; apu_rvalid = 0;
    step();
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_late_rvalid got %0b exp 0", rsp_valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy_after got %0b exp 0", busy_o); end
  endtask

  task automatic test_gnt_rvalid_same();
    clear_model();
    op_base = 6'h3C; to_push = 2;
    repeat (4) cycle();
    checks++; if (apu_req !== 1'b1) begin errors++; $display("FAIL same_req got %0b exp 1", apu_req); end
    checks++; if (apu_op_o !== 6'h3C) begin errors++; $display("FAIL same_op0 got %h exp 3c", apu_op_o); end
    apu_gnt = 1;
    cycle();
    checks++; if (apu_op_o !== 6'h3D) begin errors++; $display("FAIL same_op1 got %h exp 3d", apu_op_o); end
    auto_rv = 1;
    cycle();
    apu_gnt = 0;
    checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL same_rsp_valid got %0b exp 1", rsp_valid_o); end
    checks++; if (rsp_result_o !== 32'h200) begin errors++; $display("FAIL same_rsp_data got %h exp 00000200", rsp_result_o); end
    checks++; if (grants !== 2) begin errors++; $display("FAIL same_grants got %0d exp 2", grants); end
    cycle();
    rsp_ready_i = 1;
    repeat (4) cycle();
    checks++; if (popped_q.size() !== 2) begin errors++; $display("FAIL same_rsp_count got %0d exp 2", popped_q.size()); end
    if (popped_q.size() == 2) begin
      checks++;
      if (popped_q[1] !== 32'h201) begin errors++; $display("FAIL same_rsp1 got %h exp 00000201", popped_q[1]); end
    end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL same_busy got %0b exp 0", busy_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_credit();
    test_halt();
    test_reset_mid();
    test_gnt_rvalid_same();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
